// File: rtl/bcd_counter_2d.sv
// rtl/bcd_counter_2d.sv - two-digit BCD up/down counter with debounced buttons and auto-count
module bcd_counter_2d_debounce #(
  parameter int DB_N = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  output logic pulse
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } db_state_e;

  localparam logic [DB_N-1:0] CNT_ONE = {{(DB_N-1){1'b0}}, 1'b1};

  db_state_e       state_q, state_d;
  logic [DB_N-1:0] cnt_q, cnt_d;

  // State and stability counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a level must hold until the counter saturates before it is accepted;
  // the press pulse fires only on the accepted low-to-high transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse   = 1'b0;
    case (state_q)
      IDLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = IDLE_LO;
        end else if (cnt_q == '1) begin
          state_d = IDLE_HI;
          pulse   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = IDLE_HI;
        end else if (cnt_q == '1) begin
          state_d = IDLE_LO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

module bcd_counter_2d #(
  parameter int DB_N   = 20,
  parameter int TICK_N = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       auto_en,
  input  logic       clr,
  output logic [7:0] bcd,
  output logic       wrap
);

  localparam logic [TICK_N-1:0] PRE_ONE = {{(TICK_N-1){1'b0}}, 1'b1};

  logic [1:0]        up_sync_q, up_sync_d;
  logic [1:0]        dn_sync_q, dn_sync_d;
  logic [TICK_N-1:0] pre_q, pre_d;
  logic [7:0]        bcd_q, bcd_d;
  logic              wrap_q, wrap_d;
  logic              up_pulse, dn_pulse, tick;
  logic              inc, dec;
  logic [3:0]        units, tens;

  // Two-flop synchronizers for the raw buttons
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_sync_q <= 2'b00;
      dn_sync_q <= 2'b00;
    end else begin
      up_sync_q <= up_sync_d;
      dn_sync_q <= dn_sync_d;
    end
  end

  // Shift each raw button into its synchronizer chain
  always_comb begin
    up_sync_d = {up_sync_q[0], btn_up};
    dn_sync_d = {dn_sync_q[0], btn_dn};
  end

  bcd_counter_2d_debounce #(.DB_N(DB_N)) u_db_up (
    .clk   (clk),
    .reset (reset),
    .s     (up_sync_q[1]),
    .pulse (up_pulse)
  );

  bcd_counter_2d_debounce #(.DB_N(DB_N)) u_db_dn (
    .clk   (clk),
    .reset (reset),
    .s     (dn_sync_q[1]),
    .pulse (dn_pulse)
  );

  // Prescaler register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  // Prescaler runs only in auto mode; tick is gated so a stale value cannot fire after auto_en drops
  always_comb begin
    pre_d = auto_en ? (pre_q + PRE_ONE) : '0;
    tick  = auto_en && (pre_q == '1);
  end

  // Counter and wrap registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_q  <= 8'h00;
      wrap_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
    end
  end

  // Digit-wise BCD increment/decrement; clear wins, opposing requests cancel
  always_comb begin
    bcd_d  = bcd_q;
    wrap_d = 1'b0;
    units  = bcd_q[3:0];
    tens   = bcd_q[7:4];
    inc    = up_pulse | tick;
    dec    = dn_pulse;
    if (clr) begin
      bcd_d = 8'h00;
    end else if (inc && dec) begin
      bcd_d = bcd_q;
    end else if (inc) begin
      if (bcd_q == 8'h99) begin
        bcd_d  = 8'h00;
        wrap_d = 1'b1;
      end else if (units == 4'd9) begin
        bcd_d = {tens + 4'd1, 4'd0};
      end else begin
        bcd_d = {tens, units + 4'd1};
      end
    end else if (dec) begin
      if (bcd_q == 8'h00) begin
        bcd_d  = 8'h99;
        wrap_d = 1'b1;
      end else if (units == 4'd0) begin
        bcd_d = {tens - 4'd1, 4'd9};
      end else begin
        bcd_d = {tens, units - 4'd1};
      end
    end
  end

  assign bcd  = bcd_q;
  assign wrap = wrap_q;

endmodule
